// File: rtl/mixed_radix_counter.sv
// rtl/mixed_radix_counter.sv - multi-digit mixed-radix up/down counter with load clamp and optional limit
module mixed_radix_counter #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4,
  parameter logic [8*N_DIGITS-1:0] MODULI = 32'h060A_060A,
  parameter int LIMIT_EN = 0,
  parameter logic [N_DIGITS*DIGIT_W-1:0] LIMIT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          load,
  input  logic [N_DIGITS*DIGIT_W-1:0]   load_value,
  output logic [N_DIGITS*DIGIT_W-1:0]   value,
  output logic [N_DIGITS-1:0]           digit_wrap,
  output logic                          wrap,
  output logic                          at_zero
);

  localparam int W = N_DIGITS * DIGIT_W;

  logic [W-1:0]        nxt_value;
  logic [W-1:0]        clamped;
  logic [N_DIGITS-1:0] nxt_dwrap;
  logic                nxt_wrap;
  logic                chain;
  logic [DIGIT_W:0]    m1;
  logic [DIGIT_W-1:0]  d;

  always_comb begin
    nxt_value = value;
    nxt_dwrap = '0;
    nxt_wrap  = 1'b0;
    clamped   = '0;
    chain     = 1'b1;
    m1        = '0;
    d         = '0;
    if (load) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        m1 = (DIGIT_W+1)'(MODULI[8*i +: 8] - 8'd1);
        d  = load_value[DIGIT_W*i +: DIGIT_W];
        clamped[DIGIT_W*i +: DIGIT_W] = ({1'b0, d} > m1) ? m1[DIGIT_W-1:0] : d;
      end
      // Packed digits compare numerically in most-significant-digit-first order.
      nxt_value = (LIMIT_EN != 0 && clamped > LIMIT) ? LIMIT : clamped;
    end else if (en) begin
      if (LIMIT_EN != 0 && !dir && value == LIMIT) begin
        nxt_value = '0;
        nxt_wrap  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++)
          nxt_dwrap[i] = (value[DIGIT_W*i +: DIGIT_W] != '0);
      end else if (LIMIT_EN != 0 && dir && value == '0) begin
        nxt_value = LIMIT;
        nxt_wrap  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++)
          nxt_dwrap[i] = (LIMIT[DIGIT_W*i +: DIGIT_W] != '0);
      end else begin
        // chain is the carry (up) or borrow (down) rippling through all digits this cycle.
        for (int i = 0; i < N_DIGITS; i++) begin
          m1 = (DIGIT_W+1)'(MODULI[8*i +: 8] - 8'd1);
          d  = value[DIGIT_W*i +: DIGIT_W];
          if (chain) begin
            if (!dir) begin
              if ({1'b0, d} == m1) begin
                nxt_value[DIGIT_W*i +: DIGIT_W] = '0;
                nxt_dwrap[i] = 1'b1;
              end else begin
                nxt_value[DIGIT_W*i +: DIGIT_W] = d + 1'b1;
                chain = 1'b0;
              end
            end else begin
              if (d == '0) begin
                nxt_value[DIGIT_W*i +: DIGIT_W] = m1[DIGIT_W-1:0];
                nxt_dwrap[i] = 1'b1;
              end else begin
                nxt_value[DIGIT_W*i +: DIGIT_W] = d - 1'b1;
                chain = 1'b0;
              end
            end
          end
        end
        nxt_wrap = chain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value      <= '0;
      digit_wrap <= '0;
      wrap       <= 1'b0;
      at_zero    <= 1'b1;
    end else begin
      value      <= nxt_value;
      digit_wrap <= nxt_dwrap;
      wrap       <= nxt_wrap;
      at_zero    <= (nxt_value == '0);
    end
  end

endmodule
